// File: rtl/alu_arbiter_seq_pkg.sv
// Shared widths, ALU op encodings and arbiter FSM states for the ALU sharing controller.
package alu_arbiter_seq_pkg;

  localparam int DATA_BUS_WIDTH  = 24;
  localparam int ALU_OP_NUM_BITS = 3;

  localparam logic [ALU_OP_NUM_BITS-1:0] ALU_OP_ADD = 3'd0;
  localparam logic [ALU_OP_NUM_BITS-1:0] ALU_OP_SUB = 3'd1;
  localparam logic [ALU_OP_NUM_BITS-1:0] ALU_OP_AND = 3'd2;
  localparam logic [ALU_OP_NUM_BITS-1:0] ALU_OP_OR  = 3'd3;
  localparam logic [ALU_OP_NUM_BITS-1:0] ALU_OP_XOR = 3'd4;

  typedef enum logic [1:0] {
    ARB_ST_IDLE = 2'd0,
    ARB_ST_EXEC = 2'd1,
    ARB_ST_RESP = 2'd2
  } arb_state_e;

  function automatic logic [1:0] idx_to_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_rr_arbiter2.sv
// Two-input round-robin arbiter; the pointer flips to the other requester when a
// transaction completes, so a lone requester always wins regardless of the pointer.
module alu_rr_arbiter2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req_i,
  input  logic       done_i,
  input  logic       done_idx_i,
  output logic       grant_vld_o,
  output logic       grant_idx_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    grant_vld_o = |req_i;
    case (req_i)
      2'b01:   grant_idx_o = 1'b0;
      2'b10:   grant_idx_o = 1'b1;
      default: grant_idx_o = ptr_q;
    endcase
  end

  assign ptr_d = done_i ? ~done_idx_i : ptr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ptr_q <= 1'b0;
    else          ptr_q <= ptr_d;
  end

endmodule

// File: rtl/alu_arbiter_seq.sv
// Shares one ALU between the execute path (req 0) and the PC incrementer (req 1).
// Define ALU_ARB_PERF_CNT_EN to add per-requester completion counters.
module alu_arbiter_seq
  import alu_arbiter_seq_pkg::*;
#(
  parameter int DATA_W = DATA_BUS_WIDTH,
  parameter int OP_W   = ALU_OP_NUM_BITS
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_z,
  output logic              rsp_c,
  output logic              rsp_n,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_z,
  input  logic              alu_c,
  input  logic              alu_n
`ifdef ALU_ARB_PERF_CNT_EN
  ,
  input  logic              cnt_clr,
  output logic [15:0]       grant_cnt0,
  output logic [15:0]       grant_cnt1
`endif
);

  arb_state_e        state_q, state_d;
  logic              grant_q;
  logic [DATA_W-1:0] alu_a_q, alu_b_q, rsp_data_q;
  logic [OP_W-1:0]   alu_op_q;
  logic              rsp_z_q, rsp_c_q, rsp_n_q;
  logic              win_vld, win_idx;
  logic              accept, complete;

  alu_rr_arbiter2 u_arb (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_i       (req_valid),
    .done_i      (complete),
    .done_idx_i  (grant_q),
    .grant_vld_o (win_vld),
    .grant_idx_o (win_idx)
  );

  always_comb begin
    state_d   = state_q;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    accept    = 1'b0;
    complete  = 1'b0;
    case (state_q)
      ARB_ST_IDLE: begin
        // The winner is always a valid requester, so ready implies handshake.
        if (win_vld) begin
          req_ready = idx_to_onehot(win_idx);
          accept    = 1'b1;
          state_d   = ARB_ST_EXEC;
        end
      end
      ARB_ST_EXEC: state_d = ARB_ST_RESP;
      ARB_ST_RESP: begin
        rsp_valid = idx_to_onehot(grant_q);
        if (rsp_ready[grant_q]) begin
          complete = 1'b1;
          state_d  = ARB_ST_IDLE;
        end
      end
      default: state_d = ARB_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ARB_ST_IDLE;
      grant_q    <= 1'b0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= OP_W'(ALU_OP_ADD);
      rsp_data_q <= '0;
      rsp_z_q    <= 1'b0;
      rsp_c_q    <= 1'b0;
      rsp_n_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      // Operand registers only load on accept so the ALU inputs stay quiet otherwise.
      if (accept) begin
        grant_q  <= win_idx;
        alu_a_q  <= win_idx ? req1_a  : req0_a;
        alu_b_q  <= win_idx ? req1_b  : req0_b;
        alu_op_q <= win_idx ? req1_op : req0_op;
      end
      if (state_q == ARB_ST_EXEC) begin
        rsp_data_q <= alu_result;
        rsp_z_q    <= alu_z;
        rsp_c_q    <= alu_c;
        rsp_n_q    <= alu_n;
      end
    end
  end

  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_op   = alu_op_q;
  assign rsp_data = rsp_data_q;
  assign rsp_z    = rsp_z_q;
  assign rsp_c    = rsp_c_q;
  assign rsp_n    = rsp_n_q;

`ifdef ALU_ARB_PERF_CNT_EN
  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    logic [15:0] cnt_q;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
        cnt_q <= '0;
      else if (cnt_clr)
        cnt_q <= '0;
      else if (complete && (grant_q == 1'(gi)) && (cnt_q != 16'hFFFF))
        cnt_q <= cnt_q + 16'd1;
    end
  end
  assign grant_cnt0 = g_cnt[0].cnt_q;
  assign grant_cnt1 = g_cnt[1].cnt_q;
`endif

endmodule

// File: doc/alu_arbiter_seq.md
Name: alu_arbiter_seq

Overview:
- Shares the single datapath ALU between two requesters: port 0 is the control-unit execute path, port 1 is the PC/address incrementer.
- Each request is arbitrated, operands and op are registered and driven to the ALU for one cycle, and result plus Z/C/N flags are captured.
- The captured response is returned to the granted requester over a valid/ready handshake.
- Sits between the multicycle control unit and the ALU instance in the CPU top level.

Parameters:
- DATA_W, 24, operand/result width; equals DATA_BUS_WIDTH.
- OP_W, 3, ALU op code width; equals ALU_OP_NUM_BITS.

Ports:
- clk  in  1  system clock, rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  2  per-requester request strobe; bit i = requester i.
- req_ready  out  2  per-requester accept; one-hot or zero.
- req0_a, req0_b  in  DATA_W each  requester 0 operands.
- req0_op  in  OP_W  requester 0 ALU op.
- req1_a, req1_b  in  DATA_W each  requester 1 operands.
- req1_op  in  OP_W  requester 1 ALU op.
- rsp_valid  out  2  per-requester response valid; one-hot or zero.
- rsp_ready  in  2  per-requester response accept.
- rsp_data  out  DATA_W  captured ALU result.
- rsp_z, rsp_c, rsp_n  out  1 each  captured ALU flags.
- alu_a, alu_b  out  DATA_W each  operands to the ALU.
- alu_op  out  OP_W  op code to the ALU.
- alu_result  in  DATA_W  ALU result.
- alu_z, alu_c, alu_n  in  1 each  ALU flags.

Behaviour:
- One clock (clk). Reset is asynchronous, active-low (reset_n).
- Reset values:
  - FSM returns to IDLE.
  - req_ready=0, rsp_valid=0.
  - rsp_data=0, flags=0.
  - alu_a=0, alu_b=0, alu_op=0 (ALU_OP_ADD encoding).
  - Priority pointer points to requester 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready is combinational and goes to the winner only.
  - Winner: if exactly one req_valid bit is set, that requester wins. If both are set, the priority-pointer requester wins.
  - On handshake (valid & ready), latch the winner's a/b/op into the alu_* registers, record the grant index, and go to EXEC.
- EXEC (exactly 1 cycle):
  - alu_* outputs are stable; the ALU is combinational.
  - At the clock edge, capture alu_result into rsp_data and alu_z/c/n into rsp_z/c/n, then go to RESP.
- RESP:
  - rsp_valid[grant]=1.
  - rsp_data and flags are held stable until rsp_ready[grant]=1.
  - On acceptance, rsp_valid drops the next cycle, the priority pointer moves to the other requester (round-robin), and the FSM returns to IDLE.
- Latency: request accept at edge N, rsp_valid asserted from N+2. Minimum 3-cycle issue interval per operation (IDLE→EXEC→RESP→IDLE).
- req_ready is 0 in EXEC and RESP. A requester holds req_valid and its operands until accepted.
- A deasserted req_valid in IDLE with no handshake has no effect. The pointer does not move without a completed transaction.
- rsp_ready on the non-granted bit is ignored.
- Flags are passed through exactly as the ALU reports them; the controller never recomputes them.
- Unsupported op codes are forwarded unchanged; the ALU yields 0.
- alu_* outputs hold their last values between operations, so there is no spurious ALU toggling.
- Reset asserted mid-operation in EXEC or RESP:
  - The in-flight operation is discarded and no response is produced.
  - All outputs return to reset values immediately (asynchronous).

Optional Feature:
- Macro: ALU_ARB_PERF_CNT_EN.
- With the macro defined:
  - Two extra outputs, grant_cnt0 and grant_cnt1, 16 bits each.
  - Each increments on every completed response handshake for its requester.
  - Saturates at 0xFFFF; reset to 0.
  - Extra input cnt_clr synchronously zeroes both counters and takes priority over an increment in the same cycle.
- Without the macro: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- The shared parameters include file holds:
  - DATA_BUS_WIDTH and ALU_OP_NUM_BITS.
  - The ALU_OP_* encodings.
  - New FSM state encodings ARB_ST_IDLE=2'd0, ARB_ST_EXEC=2'd1, ARB_ST_RESP=2'd2.
- One natural sub-module: alu_rr_arbiter2, a 2-input round-robin grant with pointer update on a completion strobe.
- The FSM and operand/response registers stay in alu_arbiter_seq.

Test Plan:
- Single request: req0 ADD 0x000005+0x000003 → req_ready[0] same cycle; rsp_valid[0] two cycles after accept; rsp_data=0x000008, Z=0, C=0, N=0.
- Flags: req1 AND 0x0F0F0F & 0xF0F0F0 → rsp_data=0, rsp_z=1, rsp_c=0. Then req1 SUB 0x000003−0x000005 → rsp_data=0xFFFFFE, rsp_n=1.
- Round-robin under contention: both valid continuously after reset → grants 0,1,0,1. Each response is routed only to its rsp_valid bit, and rsp_data matches that requester's op.
- Backpressure: hold rsp_ready[0]=0 for 5 cycles in RESP → rsp_valid/rsp_data stable, req_ready=00, req1 waiting. Release → req1 granted next IDLE cycle.
- Reset mid-EXEC: assert reset_n=0 during EXEC → outputs return to reset values without a clock edge; after release, no rsp_valid appears and the next grant goes to req0.
- ALU_ARB_PERF_CNT_EN build: 3 ops for req0, 2 for req1 → grant_cnt0=3, grant_cnt1=2. Pulse cnt_clr coincident with a completion → both counters read 0.
